// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, keyboard command and
// response bytes, default 50 MHz timing and the host frame builder.
package ps2_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_INHIBIT   = 3'd1;
   localparam state_t ST_REQ       = 3'd2;
   localparam state_t ST_SEND      = 3'd3;
   localparam state_t ST_ACK       = 3'd4;
   localparam state_t ST_WAIT_IDLE = 3'd5;
   localparam state_t ST_DONE      = 3'd6;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] RSP_ACK      = 8'hFA;
   localparam logic [7:0] RSP_RESEND   = 8'hFE;

   localparam int DEF_INHIBIT_CNT   = 6_000;
   localparam int DEF_START_TIMEOUT = 750_000;
   localparam int DEF_BIT_TIMEOUT   = 100_000;
   localparam int DEF_FILTER_LEN    = 8;

   // Host frame shifted out LSB first: data bits, odd parity, stop bit.
   function automatic logic [9:0] make_frame(input logic [7:0] data);
      return {1'b1, ~^data, data};
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning: 2-FF synchronisers on clock and data, debounce on
// the clock line and a single-cycle pulse on each filtered falling edge.
// Shared between the host transmitter and the receiver.
module ps2_line_filter
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = DEF_FILTER_LEN
) (
   input  logic clk,
   input  logic rst_b,
   input  logic clk_raw,
   input  logic data_raw,
   output logic clk_filt,
   output logic data_sync,
   output logic fall
);

   localparam int CNT_W = $clog2(FILTER_LEN + 1);

   logic             clk_meta;
   logic             clk_sync;
   logic             data_meta;
   logic [CNT_W-1:0] stable_cnt;

   // Synchronise both pads; reset to 1 because released lines idle high.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         clk_meta  <= 1'b1;
         clk_sync  <= 1'b1;
         data_meta <= 1'b1;
         data_sync <= 1'b1;
      end else begin
         clk_meta  <= clk_raw;
         clk_sync  <= clk_meta;
         data_meta <= data_raw;
         data_sync <= data_meta;
      end
   end

   // Accept a new clock level only after FILTER_LEN consecutive differing samples.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         clk_filt   <= 1'b1;
         stable_cnt <= '0;
         fall       <= 1'b0;
      end else begin
         fall <= 1'b0;
         if (clk_sync == clk_filt) begin
            stable_cnt <= '0;
         end else if (stable_cnt == CNT_W'(FILTER_LEN - 1)) begin
            clk_filt   <= clk_sync;
            stable_cnt <= '0;
            fall       <= clk_filt;
         end else begin
            stable_cnt <= stable_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift the byte
// out on device clocks, check the ACK bit, report done/error.
// Optional macro PS2_TX_RETRY_EN: failed attempts are retried up to twice
// before done/error are reported.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CNT   = DEF_INHIBIT_CNT,
   parameter int START_TIMEOUT = DEF_START_TIMEOUT,
   parameter int BIT_TIMEOUT   = DEF_BIT_TIMEOUT,
   parameter int FILTER_LEN    = DEF_FILTER_LEN
) (
   input  logic       clk,
   input  logic       rst_b,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       done,
   output logic       error,
   output logic       rx_inhibit,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int MAX_A   = (START_TIMEOUT > BIT_TIMEOUT) ? START_TIMEOUT : BIT_TIMEOUT;
   localparam int MAX_CNT = (MAX_A > INHIBIT_CNT) ? MAX_A : INHIBIT_CNT;
   localparam int TIMER_W = $clog2(MAX_CNT + 1);

   state_t             state, state_n;
   logic [TIMER_W-1:0] timer, timer_n, limit;
   logic [3:0]         idx, idx_n;
   logic [9:0]         shift, shift_n;
   logic               clk_oe_n, data_oe_n;
   logic               failed, failed_n;
   logic               fail, finish;
   logic               clk_filt, data_sync, fall;
`ifdef PS2_TX_RETRY_EN
   logic [1:0]         tries, tries_n;
`endif

   ps2_line_filter #(
      .FILTER_LEN(FILTER_LEN)
   ) u_filter (
      .clk      (clk),
      .rst_b    (rst_b),
      .clk_raw  (ps2_clk_in),
      .data_raw (ps2_data_in),
      .clk_filt (clk_filt),
      .data_sync(data_sync),
      .fall     (fall)
   );

   assign tx_ready   = (state == ST_IDLE);
   assign rx_inhibit = (state != ST_IDLE);
   assign done       = (state == ST_DONE);
   assign error      = (state == ST_DONE) && failed;

   // Next-state logic; a fall always beats a coinciding timeout, and any
   // attempt end (good or bad) funnels through one release/retry path.
   always_comb begin
      state_n   = state;
      timer_n   = timer;
      idx_n     = idx;
      shift_n   = shift;
      clk_oe_n  = ps2_clk_oe;
      data_oe_n = ps2_data_oe;
      failed_n  = failed;
      fail      = 1'b0;
      finish    = 1'b0;
`ifdef PS2_TX_RETRY_EN
      tries_n   = tries;
`endif
      limit = (state == ST_SEND && idx == 4'd0) ? TIMER_W'(START_TIMEOUT - 1)
                                                 : TIMER_W'(BIT_TIMEOUT - 1);
      case (state)
         ST_IDLE: begin
            if (tx_valid) begin
               shift_n   = make_frame(tx_data);
               state_n   = ST_INHIBIT;
               timer_n   = '0;
               clk_oe_n  = 1'b1;
               data_oe_n = 1'b0;
               failed_n  = 1'b0;
`ifdef PS2_TX_RETRY_EN
               tries_n   = 2'd0;
`endif
            end
         end
         ST_INHIBIT: begin
            if (timer == TIMER_W'(INHIBIT_CNT - 1)) begin
               state_n   = ST_REQ;
               data_oe_n = 1'b1;
               timer_n   = '0;
            end else begin
               timer_n = timer + TIMER_W'(1);
            end
         end
         ST_REQ: begin
            state_n  = ST_SEND;
            clk_oe_n = 1'b0;
            idx_n    = 4'd0;
            timer_n  = '0;
         end
         ST_SEND: begin
            if (fall) begin
               data_oe_n = ~shift[idx];
               idx_n     = idx + 4'd1;
               timer_n   = '0;
               if (idx == 4'd9) state_n = ST_ACK;
            end else if (timer == limit) begin
               fail = 1'b1;
            end else begin
               timer_n = timer + TIMER_W'(1);
            end
         end
         ST_ACK: begin
            if (fall) begin
               failed_n = data_sync;
               state_n  = ST_WAIT_IDLE;
               timer_n  = '0;
            end else if (timer == limit) begin
               fail = 1'b1;
            end else begin
               timer_n = timer + TIMER_W'(1);
            end
         end
         ST_WAIT_IDLE: begin
            if (clk_filt && data_sync) begin
               finish = 1'b1;
            end else if (fall) begin
               timer_n = '0;
            end else if (timer == limit) begin
               fail = 1'b1;
            end else begin
               timer_n = timer + TIMER_W'(1);
            end
         end
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase

      if (fail) failed_n = 1'b1;
      if (fail || finish) begin
         clk_oe_n  = 1'b0;
         data_oe_n = 1'b0;
         timer_n   = '0;
         state_n   = ST_DONE;
`ifdef PS2_TX_RETRY_EN
         if (failed_n && tries != 2'd2) begin
            tries_n  = tries + 2'd1;
            failed_n = 1'b0;
            clk_oe_n = 1'b1;
            state_n  = ST_INHIBIT;
         end
`endif
      end
   end

   // State and line-drive registers; reset releases both lines at once.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state       <= ST_IDLE;
         timer       <= '0;
         idx         <= 4'd0;
         shift       <= '0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         failed      <= 1'b0;
`ifdef PS2_TX_RETRY_EN
         tries       <= 2'd0;
`endif
      end else begin
         state       <= state_n;
         timer       <= timer_n;
         idx         <= idx_n;
         shift       <= shift_n;
         ps2_clk_oe  <= clk_oe_n;
         ps2_data_oe <= data_oe_n;
         failed      <= failed_n;
`ifdef PS2_TX_RETRY_EN
         tries       <= tries_n;
`endif
      end
   end

endmodule
